// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter in front of a single main-memory port. One request is
// granted at a time; its write enable, address and write data are latched at
// the grant, so the requester may change its inputs afterwards without effect.
// Writes complete without waiting on memory. Reads wait for mem_data_ready and
// give up with err=1 after TIMEOUT wait cycles. Ties are broken round-robin.
//
// Ports:
//   clk             single clock, rising-edge
//   reset_n         asynchronous active-low reset
//   req[1:0]        per-requester request (bit i = requester i)
//   we[1:0]         per-requester write enable (1 = write, 0 = read)
//   addr            requester i word address in slice i
//   wdata           requester i write data in slice i
//   ack[1:0]        one-cycle completion pulse to the served requester
//   rdata           read data, valid while ack is high
//   err             read timeout flag, valid while ack is high
//   busy            high whenever the FSM is not in IDLE
//   mem_write_en    write strobe to main memory (one cycle, during ISSUE)
//   mem_add         main-memory address
//   mem_data_in     main-memory write data
//   mem_data_out    main-memory read data
//   mem_data_ready  main memory has read data valid
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 req,
    input  logic [1:0]                 we,
    input  logic [2*ADDRESS_WIDTH-1:0] addr,
    input  logic [2*DATA_WIDTH-1:0]    wdata,
    output logic [1:0]                 ack,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       err,
    output logic                       busy,
    output logic                       mem_write_en,
    output logic [ADDRESS_WIDTH-1:0]   mem_add,
    output logic [DATA_WIDTH-1:0]      mem_data_in,
    input  logic [DATA_WIDTH-1:0]      mem_data_out,
    input  logic                       mem_data_ready
);

    // The wait counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits
    // suffice; a single bit is kept for the degenerate TIMEOUT=1 case.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               last_grant;
    logic               cur_id;
    logic               cur_we;
    logic [CNT_W-1:0]   wait_cnt;

    logic               grant_valid;
    logic               grant_id;
    logic               sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic               wait_done;

    // Arbitration: a lone request wins outright; on a tie the requester that
    // was not served last time wins. The selected requester's fields are
    // muxed out here so the register block below only has to latch them.
    always_comb begin
        grant_valid = (state == IDLE) && (req != 2'b00);
        grant_id    = 1'b0;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        sel_we    = grant_id ? we[1] : we[0];
        sel_addr  = grant_id ? addr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                             : addr[ADDRESS_WIDTH-1:0];
        sel_wdata = grant_id ? wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                             : wdata[DATA_WIDTH-1:0];
    end

    // The last WAIT cycle before giving up is the one where the counter has
    // already counted TIMEOUT-1 unanswered cycles.
    assign wait_done = (wait_cnt == WAIT_LAST);

    assign busy = (state != IDLE);

    // State register; reset drops any in-flight transaction back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Writes skip WAIT because memory needs no handshake
    // for them; ready is only looked at while in WAIT so a level left over
    // from an earlier read cannot complete a new one early.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = cur_we ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_data_ready || wait_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping and the memory-side outputs. The latched address and
    // data double as mem_add/mem_data_in, so they are already presented on
    // the memory port throughout ISSUE; the write strobe lasts one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant   <= 1'b1;
            cur_id       <= 1'b0;
            cur_we       <= 1'b0;
            mem_add      <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            if (grant_valid) begin
                last_grant   <= grant_id;
                cur_id       <= grant_id;
                cur_we       <= sel_we;
                mem_add      <= sel_addr;
                mem_data_in  <= sel_wdata;
                mem_write_en <= sel_we;
            end
        end
    end

    // Wait counter: runs only while a read sits unanswered in WAIT and is
    // cleared everywhere else, so every read starts counting from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && !mem_data_ready && !wait_done) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Response registers. rdata/err only change on the edge that enters
    // RESP, so they stay stable from one response to the next. A write
    // leaves rdata alone but clears err so a write ack never reports an
    // error. ack is registered from RESP, giving a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
            err   <= 1'b0;
            ack   <= 2'b00;
        end else begin
            if ((state == WAIT) && mem_data_ready) begin
                rdata <= mem_data_out;
                err   <= 1'b0;
            end else if ((state == WAIT) && wait_done) begin
                rdata <= '0;
                err   <= 1'b1;
            end else if ((state == ISSUE) && cur_we) begin
                err   <= 1'b0;
            end

            if (state == RESP) begin
                ack <= cur_id ? 2'b10 : 2'b01;
            end else begin
                ack <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (ADDRESS_WIDTH=16, DATA_WIDTH=32,
// TIMEOUT=4). Inputs are driven and outputs sampled on the falling edge, so
// every "@(negedge clk)" below steps over exactly one rising edge of the DUT.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk;
    logic            reset_n;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            busy;
    logic            mem_write_en;
    logic [AW-1:0]   mem_add;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;
    logic            mem_data_ready;

    int checks;
    int fails;

    mem_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT       (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .ack            (ack),
        .rdata          (rdata),
        .err            (err),
        .busy           (busy),
        .mem_write_en   (mem_write_en),
        .mem_add        (mem_add),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_ready (mem_data_ready)
    );

    // 10-unit clock, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset asserted from a deasserted start so the async edge really fires.
    task test_reset;
        reset_n = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
        mem_data_out = '0; mem_data_ready = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL reset_ack: got %b want 00", ack); end
        checks++; if (mem_write_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_wen: got %b want 0", mem_write_en); end
        checks++; if (mem_add !== 16'h0000) begin fails++; $display("[TB] FAIL reset_add: got %h want 0000", mem_add); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin fails++; $display("[TB] FAIL reset_rdata_err: got %h/%b want 0/0", rdata, err); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Requester 0 writes 0xDEADBEEF to 0x10; ack two edges after the grant.
    task test_single_write;
        req = 2'b01; we = 2'b01; addr = 32'h0000_0010; wdata = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        checks++; if (mem_write_en !== 1'b1) begin fails++; $display("[TB] FAIL wr_issue_wen: got %b want 1", mem_write_en); end
        checks++; if (mem_add !== 16'h0010) begin fails++; $display("[TB] FAIL wr_issue_add: got %h want 0010", mem_add); end
        checks++; if (mem_data_in !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL wr_issue_data: got %h want deadbeef", mem_data_in); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL wr_issue_busy: got %b want 1", busy); end
        req = 2'b00; addr = 32'hFFFF_FFFF; wdata = '1;
        @(negedge clk);
        checks++; if (mem_write_en !== 1'b0) begin fails++; $display("[TB] FAIL wr_resp_wen: got %b want 0", mem_write_en); end
        checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL wr_early_ack: got %b want 00", ack); end
        @(negedge clk);
        checks++; if (ack !== 2'b01) begin fails++; $display("[TB] FAIL wr_ack: got %b want 01", ack); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL wr_err: got %b want 0", err); end
        @(negedge clk);
        checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL wr_ack_width: got %b want 00", ack); end
    endtask

    // Requester 1 reads 0x10, memory ready in the first WAIT cycle.
    task test_single_read;
        req = 2'b10; we = 2'b00; addr = {16'h0010, 16'h0000};
        mem_data_out = 32'hDEADBEEF; mem_data_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_write_en !== 1'b0) begin fails++; $display("[TB] FAIL rd_issue_wen: got %b want 0", mem_write_en); end
        checks++; if (mem_add !== 16'h0010) begin fails++; $display("[TB] FAIL rd_issue_add: got %h want 0010", mem_add); end
        req = 2'b00;
        @(negedge clk);
        mem_data_ready = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL rd_early_ack: got %b want 00", ack); end
        mem_data_ready = 1'b0; mem_data_out = 32'h0;
        @(negedge clk);
        checks++; if (ack !== 2'b10) begin fails++; $display("[TB] FAIL rd_ack: got %b want 10", ack); end
        checks++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL rd_data: got %h want deadbeef", rdata); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL rd_err: got %b want 0", err); end
        @(negedge clk);
        checks++; if (ack !== 2'b00 || rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL rd_after: got ack %b rdata %h want 00 deadbeef", ack, rdata); end
    endtask

    // Both requesters write continuously; last grant was 1 so 0 goes first.
    task test_contention;
        logic          exp_id;
        logic [AW-1:0] exp_add;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_ack;
        req = 2'b11; we = 2'b11; addr = {16'h0200, 16'h0100};
        wdata = {32'hCAFEF00D, 32'h1111_1111};
        for (int k = 0; k < 4; k++) begin
            exp_id   = (k % 2) == 1;
            exp_add  = exp_id ? 16'h0200 : 16'h0100;
            exp_data = exp_id ? 32'hCAFEF00D : 32'h1111_1111;
            exp_ack  = exp_id ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++; if (mem_write_en !== 1'b1 || mem_add !== exp_add) begin fails++; $display("[TB] FAIL rr_grant%0d: got wen %b add %h want 1 %h", k, mem_write_en, mem_add, exp_add); end
            checks++; if (mem_data_in !== exp_data) begin fails++; $display("[TB] FAIL rr_data%0d: got %h want %h", k, mem_data_in, exp_data); end
            checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL rr_ack_width%0d: got %b want 00", k, ack); end
            @(negedge clk);
            checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL rr_early_ack%0d: got %b want 00", k, ack); end
            @(negedge clk);
            checks++; if (ack !== exp_ack) begin fails++; $display("[TB] FAIL rr_ack%0d: got %b want %b", k, ack, exp_ack); end
        end
        req = 2'b00;
        @(negedge clk);
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rr_idle: got ack %b busy %b want 00 0", ack, busy); end
    endtask

    // Reset during WAIT of a read; afterwards a tie must go to requester 0
    // even though requester 0 was the last one granted before the reset.
    task test_reset_mid_op;
        req = 2'b01; we = 2'b00; addr = {16'h0000, 16'h0030}; mem_data_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_add !== 16'h0030) begin fails++; $display("[TB] FAIL mid_issue_add: got %h want 0030", mem_add); end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ack !== 2'b00) begin fails++; $display("[TB] FAIL mid_rst_busy_ack: got %b %b want 0 00", busy, ack); end
        checks++; if (mem_add !== 16'h0 || mem_data_in !== 32'h0 || mem_write_en !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_mem: got %h %h %b want 0 0 0", mem_add, mem_data_in, mem_write_en); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_rdata: got %h %b want 0 0", rdata, err); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL mid_rst_noack: got %b want 00", ack); end
        reset_n = 1'b1;
        req = 2'b11; we = 2'b11; addr = {16'h0200, 16'h0100};
        wdata = {32'hCAFEF00D, 32'h1111_1111};
        @(negedge clk);
        checks++; if (mem_write_en !== 1'b1 || mem_add !== 16'h0100) begin fails++; $display("[TB] FAIL mid_regrant: got wen %b add %h want 1 0100", mem_write_en, mem_add); end
        req = 2'b00;
        @(negedge clk);
        checks++; if (ack !== 2'b00) begin fails++; $display("[TB] FAIL mid_early_ack: got %b want 00", ack); end
        @(negedge clk);
        checks++; if (ack !== 2'b01) begin fails++; $display("[TB] FAIL mid_ack: got %b want 01", ack); end
        @(negedge clk);
    endtask

    // Read with ready high only before WAIT, then low: must time out after
    // four WAIT cycles with err=1 and rdata=0.
    task test_timeout;
        req = 2'b10; we = 2'b00; addr = {16'h0020, 16'h0000};
        mem_data_out = 32'h1234_5678; mem_data_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_add !== 16'h0020) begin fails++; $display("[TB] FAIL to_issue_add: got %h want 0020", mem_add); end
        mem_data_ready = 1'b0; req = 2'b00;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checks++; if (ack !== 2'b00 || busy !== 1'b1) begin fails++; $display("[TB] FAIL to_wait%0d: got ack %b busy %b want 00 1", i, ack, busy); end
        end
        @(negedge clk);
        checks++; if (ack !== 2'b00 || busy !== 1'b1) begin fails++; $display("[TB] FAIL to_resp: got ack %b busy %b want 00 1", ack, busy); end
        @(negedge clk);
        checks++; if (ack !== 2'b10) begin fails++; $display("[TB] FAIL to_ack: got %b want 10", ack); end
        checks++; if (err !== 1'b1 || rdata !== 32'h0) begin fails++; $display("[TB] FAIL to_err_rdata: got %b %h want 1 0", err, rdata); end
        @(negedge clk);
        checks++; if (ack !== 2'b00 || err !== 1'b1) begin fails++; $display("[TB] FAIL to_after: got ack %b err %b want 00 1", ack, err); end
    endtask

    // Test sequence; order matters because the round-robin pointer carries
    // over from one scenario to the next.
    initial begin
        checks = 0;
        fails  = 0;
        test_reset;
        test_single_write;
        test_single_read;
        test_contention;
        test_reset_mid_op;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
